// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: CPU, host and data_mem buses around the data memory arbiter
// slave modport is the arbiter side; master modport is the requesters/memory side.
interface data_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [47:0] cpu_wdata;
  logic [47:0] cpu_rdata;
  logic        cpu_stall;
  logic        host_req;
  logic        host_we;
  logic [31:0] host_addr;
  logic [47:0] host_wdata;
  logic        host_gnt;
  logic [47:0] host_rdata;
  logic        host_rvalid;
  logic        oob_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [47:0] mem_wd;
  logic [47:0] mem_rd;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, host_req, host_we, host_addr, host_wdata, mem_rd,
    output cpu_rdata, cpu_stall, host_gnt, host_rdata, host_rvalid, oob_err, mem_we, mem_a, mem_wd
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, host_req, host_we, host_addr, host_wdata, mem_rd,
    input  cpu_rdata, cpu_stall, host_gnt, host_rdata, host_rvalid, oob_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: single-port data memory arbiter, CPU priority with forced host slot on starvation
// clk/rst_n: clock and synchronous active-low reset.
// bus (slave): CPU port (combinational rdata, stall), host port (req/gnt, registered rdata/rvalid),
//   sticky oob_err, and the data_mem side (mem_we/mem_a/mem_wd out, mem_rd in).
module data_mem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int DEPTH = 10924
) (
  input logic clk,
  input logic rst_n,
  data_mem_arbiter_if.slave bus
);
  logic [3:0] starve_cnt;
  logic force_host;
  logic oob_hit;
  function automatic logic in_range(input logic [31:0] a);
    return a[31:14] == '0 && 32'(a[13:2]) < DEPTH;
  endfunction
  assign force_host = starve_cnt == 4'(MAX_WAIT);
  assign bus.host_gnt = rst_n & bus.host_req & (~bus.cpu_req | force_host);
  assign bus.cpu_stall = rst_n & bus.cpu_req & bus.host_gnt;
  assign bus.mem_a = bus.host_gnt ? bus.host_addr : bus.cpu_addr;
  assign bus.mem_wd = bus.host_gnt ? bus.host_wdata : bus.cpu_wdata;
  assign bus.mem_we = in_range(bus.mem_a) & (bus.host_gnt ? bus.host_we : rst_n & bus.cpu_req & bus.cpu_we);
  assign bus.cpu_rdata = bus.mem_rd;
  // a stalled CPU access never reaches memory, so only the muxed address can flag
  assign oob_hit = ~in_range(bus.mem_a) & (bus.host_gnt | (rst_n & bus.cpu_req));
  always_ff @(posedge clk)
    if (!rst_n) begin
      starve_cnt <= '0;
      bus.host_rdata <= '0;
      bus.host_rvalid <= 1'b0;
      bus.oob_err <= 1'b0;
    end else begin
      starve_cnt <= (bus.host_gnt || !bus.host_req) ? '0 : (bus.cpu_req && !force_host) ? starve_cnt + 4'd1 : starve_cnt;
      bus.host_rvalid <= bus.host_gnt & ~bus.host_we;
      if (bus.host_gnt && !bus.host_we) bus.host_rdata <= bus.mem_rd;
      bus.oob_err <= bus.oob_err | oob_hit;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH = 10924;
  typedef struct {
    int          due;
    logic [47:0] d;
  } rd_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int refusals = 0;
  bit oob_m = 1'b0;
  bit gnt_m;
  bit gnt_dut;
  bit stall_dut;
  rd_t rq[$];
  logic [47:0] dmem [4096] = '{default: '0};
  logic [47:0] sm [4096] = '{default: '0};
  always #5 clk = ~clk;
  data_mem_arbiter_if bus();
  data_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.mem_rd = dmem[bus.mem_a[13:2]];
  always @(posedge clk) if (bus.mem_we) dmem[bus.mem_a[13:2]] <= bus.mem_wd;
  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'h4000 && int'(a[13:2]) < DEPTH;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", n, cyc, a, e);
    end
  endtask
  // reference: the host is refused while the CPU wants memory, unless it has already
  // been refused MAX_WAIT times in a row; the memory image is kept in sm
  task automatic step();
    bit ge, se, we_e, ok;
    logic [31:0] a_e;
    logic [47:0] wd_e;
    @(negedge clk);
    ge = rst_n && bus.host_req && (!bus.cpu_req || refusals == MAX_WAIT);
    se = rst_n && bus.cpu_req && ge;
    a_e = ge ? bus.host_addr : bus.cpu_addr;
    wd_e = ge ? bus.host_wdata : bus.cpu_wdata;
    ok = in_rng(a_e);
    we_e = ok && (ge ? bus.host_we : rst_n && bus.cpu_req && bus.cpu_we);
    chk("host_gnt", bus.host_gnt, ge);
    chk("cpu_stall", bus.cpu_stall, se);
    chk("mem_we", bus.mem_we, we_e);
    chk("mem_a", bus.mem_a, a_e);
    chk("mem_wd", bus.mem_wd, wd_e);
    chk("cpu_rdata", bus.cpu_rdata, sm[a_e[13:2]]);
    chk("oob_err", bus.oob_err, oob_m);
    gnt_m = ge;
    gnt_dut = bus.host_gnt;
    stall_dut = bus.cpu_stall;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      refusals = 0;
      oob_m = 1'b0;
    end else begin
      if (ge && !bus.host_we) rq.push_back('{cyc, sm[a_e[13:2]]});
      if (we_e) sm[a_e[13:2]] = wd_e;
      if (!ok && (ge || bus.cpu_req)) oob_m = 1'b1;
      refusals = (ge || !bus.host_req) ? 0 : (refusals < MAX_WAIT ? refusals + 1 : refusals);
    end
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (rq.size() != 0 && rq[0].due == cyc) begin
      chk("host_rvalid", bus.host_rvalid, 1'b1);
      chk("host_rdata", bus.host_rdata, rq[0].d);
      void'(rq.pop_front());
    end else chk("host_rvalid idle", bus.host_rvalid, 1'b0);
  end
  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) << 2 | 32'($urandom_range(0, 3));
    return ($urandom_range(0, 99) == 0) ? (a | 32'h0001_0000) : a;
  endfunction
  initial begin
    int gi, ns, ng;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'h20;
    bus.cpu_wdata = 48'h111111111111;
    bus.host_req = 1'b1;
    bus.host_we = 1'b1;
    bus.host_addr = 32'h10;
    bus.host_wdata = 48'h222222222222;
    step();
    step();
    chk("reset host_rvalid", bus.host_rvalid, 1'b0);
    chk("reset host_rdata", bus.host_rdata, 48'h0);
    chk("reset oob_err", bus.oob_err, 1'b0);
    rst_n = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.host_wdata = 48'h060504030201;
    step();
    chk("host write gnt", gnt_dut, 1'b1);
    bus.host_we = 1'b0;
    step();
    bus.host_req = 1'b0;
    step();
    chk("host read data", bus.host_rdata, 48'h060504030201);
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h30;
    bus.host_req = 1'b1;
    gi = -1;
    ns = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (gnt_dut && gi < 0) gi = i;
      if (stall_dut) ns++;
      if (gnt_m) bus.host_req = 1'b0;
    end
    chk("contention grant cycle", 32'(gi), 32'(MAX_WAIT));
    chk("contention stalls", 32'(ns), 32'd1);
    bus.host_req = 1'b1;
    ns = 0;
    ng = 0;
    for (int i = 0; i < 8; i++) begin
      bus.cpu_req = (i % 2) == 0;
      step();
      if (stall_dut) ns++;
      if (gnt_dut) begin
        ng++;
        bus.host_addr = 32'(ng) << 2;
      end
    end
    chk("alternate stalls", 32'(ns), 32'd0);
    chk("alternate grants", 32'(ng), 32'd4);
    bus.host_req = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'h0000_AAB4;
    step();
    chk("oob set", bus.oob_err, 1'b1);
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("oob sticky", bus.oob_err, 1'b1);
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h8;
    bus.host_req = 1'b1;
    bus.host_addr = 32'h10;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("oob cleared", bus.oob_err, 1'b0);
    gi = -1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (gnt_dut && gi < 0) gi = i;
      if (gnt_m) bus.host_req = 1'b0;
    end
    chk("post-reset grant cycle", 32'(gi), 32'(MAX_WAIT));
    bus.host_req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.cpu_req = $urandom_range(0, 3) != 0;
      bus.cpu_we = $urandom_range(0, 2) == 0;
      bus.cpu_addr = raddr();
      bus.cpu_wdata = {$urandom(), 16'($urandom())};
      if (!bus.host_req && $urandom_range(0, 2) == 0) begin
        bus.host_req = 1'b1;
        bus.host_we = $urandom_range(0, 1) == 0;
        bus.host_addr = raddr();
        bus.host_wdata = {$urandom(), 16'($urandom())};
      end
      if (i == 1500) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      if (gnt_m) bus.host_req = 1'b0;
    end
    bus.cpu_req = 1'b0;
    bus.host_req = 1'b0;
    step();
    step();
    chk("read queue drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
